ul8_execute_unit: RTL and testbench

Execute/writeback stage of the UL8 CPU, directly downstream of the fetch/decode sequencer.
- Input: one decoded instruction per `start` pulse: 3-bit opcode (IR[7:5]), 5-bit parameter (IR[4:0]), already-incremented PC.
- Work: performs the operation against the accumulator and the 32-byte RAM through a req/ack memory port.
- Output: new accumulator, next PC, flags and a one-cycle `done` back to the sequencer.

---
 rtl/ul8_execute_unit.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ul8_execute_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ul8_execute_unit.sv
// -----------------------------------------------------------------------------
// ul8_execute_unit
//
// Execute/writeback stage of the UL8 CPU. This stage takes one decoded
// instruction per start pulse and runs it against the accumulator and a
// 32-byte RAM. The RAM is reached through a req/ack port. The stage then
// returns the new accumulator, the next PC, the flags and a one-cycle done
// pulse to the fetch/decode sequencer.
//
// Optional feature:
//   UL8_MEM_TIMEOUT_EN - when defined, the stage abandons a memory request
//   that has gone unacknowledged for TIMEOUT_CYCLES cycles. It then raises
//   the sticky err flag, pulses done and parks in HALT. When the macro is
//   undefined, the stage waits for an ack forever and err stays 0.
//
// Parameters:
//   TIMEOUT_CYCLES  memory-ack wait limit (used only with UL8_MEM_TIMEOUT_EN)
//
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   start      in   instruction valid pulse, sampled only in IDLE
//   opcode     in   [2:0] instruction opcode (IR[7:5])
//   param      in   [4:0] RAM address or immediate (IR[4:0])
//   pc_in      in   [7:0] PC after the decode increment
//   mem_addr   out  [4:0] RAM address
//   mem_rd     out  read request, held until ack
//   mem_wr     out  write request, held until ack
//   mem_wdata  out  [7:0] write data
//   mem_rdata  in   [7:0] read data, valid with mem_ack
//   mem_ack    in   memory completion
//   akku       out  [7:0] accumulator
//   pc_next    out  [7:0] PC for the next fetch
//   zero       out  last accumulator result was zero
//   carry      out  ADD carry-out / SUB borrow
//   done       out  one-cycle completion pulse
//   busy       out  high in MEM and WB
//   halted     out  sticky halt
//   err        out  sticky timeout error
// -----------------------------------------------------------------------------
module ul8_execute_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [4:0] param,
    input  logic [7:0] pc_in,
    output logic [4:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic [7:0] akku,
    output logic [7:0] pc_next,
    output logic       zero,
    output logic       carry,
    output logic       done,
    output logic       busy,
    output logic       halted,
    output logic       err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    logic [1:0] r_state;
    logic [2:0] r_opcode;
    logic [4:0] r_param;
    logic [7:0] r_pc;
    logic [7:0] r_rdata;
    logic       r_wb_armed;

    logic [7:0] r_akku;
    logic [7:0] r_pc_next;
    logic       r_zero;
    logic       r_carry;
    logic       r_done;
    logic       r_busy;
    logic       r_halted;
    logic       r_mem_rd;
    logic       r_mem_wr;
    logic [4:0] r_mem_addr;
    logic [7:0] r_mem_wdata;

    // Arithmetic on the captured operand. The 9-bit sum carries the ADD
    // carry-out in bit 8.
    logic [8:0] w_sum;
    logic [7:0] w_diff;
    logic       w_borrow;
    logic [7:0] w_jump_target;

    assign w_sum         = {1'b0, r_akku} + {1'b0, r_rdata};
    assign w_diff        = r_akku - r_rdata;
    assign w_borrow      = (r_akku < r_rdata);
    assign w_jump_target = {3'b000, r_param};

`ifdef UL8_MEM_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
`else
    // The parameter only matters when the timeout is built in.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // NOTE: every register here is sequential state, so all of them use
    // non-blocking assignments. A blocking assignment would let later
    // statements in the same edge see the new value, which silently changes
    // the behaviour.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_opcode    <= 3'd0;
            r_param     <= 5'd0;
            r_pc        <= 8'd0;
            r_rdata     <= 8'd0;
            r_wb_armed  <= 1'b0;
            r_akku      <= 8'd0;
            r_pc_next   <= 8'd0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 5'd0;
            r_mem_wdata <= 8'd0;
`ifdef UL8_MEM_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opcode <= opcode;
                        r_param  <= param;
                        r_pc     <= pc_in;
                        r_busy   <= 1'b1;
                        // Opcodes 000-011 all touch RAM. Only STA writes.
                        if (opcode[2] == 1'b0) begin
                            r_state     <= S_MEM;
                            r_mem_rd    <= (opcode != OP_STA);
                            r_mem_wr    <= (opcode == OP_STA);
                            r_mem_addr  <= param;
                            r_mem_wdata <= r_akku;
`ifdef UL8_MEM_TIMEOUT_EN
                            r_to_cnt    <= '0;
`endif
                        end else begin
                            // Non-memory ops spend one settle cycle in WB.
                            // Their results then land two edges after start,
                            // which matches a zero-wait memory op.
                            r_state    <= S_WB;
                            r_wb_armed <= 1'b0;
                        end
                    end
                end

                S_MEM: begin
                    if (mem_ack) begin
                        r_rdata    <= mem_rdata;
                        r_mem_rd   <= 1'b0;
                        r_mem_wr   <= 1'b0;
                        r_wb_armed <= 1'b1;
                        r_state    <= S_WB;
                    end
`ifdef UL8_MEM_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        // Give up on the request. The architectural state
                        // is left untouched and the stage parks in HALT.
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_halted <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_HALT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end

                S_WB: begin
                    if (!r_wb_armed) begin
                        r_wb_armed <= 1'b1;
                    end else begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_pc_next <= r_pc;
                        case (r_opcode)
                            OP_LDA: begin
                                r_akku <= r_rdata;
                                r_zero <= (r_rdata == 8'd0);
                            end
                            OP_ADD: begin
                                r_akku  <= w_sum[7:0];
                                r_carry <= w_sum[8];
                                r_zero  <= (w_sum[7:0] == 8'd0);
                            end
                            OP_SUB: begin
                                r_akku  <= w_diff;
                                r_carry <= w_borrow;
                                r_zero  <= (w_diff == 8'd0);
                            end
                            OP_JMP: begin
                                r_pc_next <= w_jump_target;
                            end
                            OP_JZ: begin
                                if (r_akku == 8'd0) begin
                                    r_pc_next <= w_jump_target;
                                end
                            end
                            OP_LDI: begin
                                r_akku <= w_jump_target;
                                r_zero <= (r_param == 5'd0);
                            end
                            default: begin
                                // STA and HLT leave the accumulator and
                                // flags alone.
                            end
                        endcase
                        if (r_opcode == OP_HLT) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_state  <= S_IDLE;
                        end
                    end
                end

                S_HALT: begin
                    // Only reset leaves HALT.
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;
    assign akku      = r_akku;
    assign pc_next   = r_pc_next;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign done      = r_done;
    assign busy      = r_busy;
    assign halted    = r_halted;
`ifdef UL8_MEM_TIMEOUT_EN
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_ul8_execute_unit.sv
// -----------------------------------------------------------------------------
// tb_ul8_execute_unit
//
// Self-checking bench for ul8_execute_unit. The bench holds a small
// instruction-level model of the accumulator, the flags, the PC and the
// 32-byte RAM. It plays the memory side of the req/ack port with a chosen
// number of wait cycles, and compares every DUT result with the model at the
// exact cycle the result is due. The timeout path is exercised when
// UL8_MEM_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_ul8_execute_unit;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [2:0] opcode;
    logic [4:0] param;
    logic [7:0] pc_in;
    logic [4:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] akku;
    logic [7:0] pc_next;
    logic       zero;
    logic       carry;
    logic       done;
    logic       busy;
    logic       halted;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    // Model state.
    logic [7:0] ram [32];
    logic [7:0] m_akku;
    logic [7:0] m_pc;
    logic       m_zero;
    logic       m_carry;
    logic       m_halted;

    ul8_execute_unit #(.TIMEOUT_CYCLES(15)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .opcode    (opcode),
        .param     (param),
        .pc_in     (pc_in),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .akku      (akku),
        .pc_next   (pc_next),
        .zero      (zero),
        .carry     (carry),
        .done      (done),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_akku   = 8'h00;
        m_pc     = 8'h00;
        m_zero   = 1'b0;
        m_carry  = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".akku"},    akku,      0);
        check({tag, ".pc_next"}, pc_next,   0);
        check({tag, ".flags"},   {zero, carry, done, busy, halted, err}, 0);
        check({tag, ".mem_req"}, {mem_rd, mem_wr}, 0);
        check({tag, ".mem_bus"}, {mem_addr, mem_wdata}, 0);
    endtask

    // Runs one instruction. The model is updated from the instruction's
    // meaning and then compared with the DUT at the due cycle. wait_n is the
    // number of cycles the memory holds back its ack. With stray set, an
    // extra start pulse is driven while the DUT is busy.
    task automatic exec(input logic [2:0] op, input logic [4:0] prm, input logic [7:0] pc,
                        input int wait_n, input bit stray);
        bit         is_mem;
        logic [7:0] operand;
        logic [7:0] old_akku;
        int         s;

        is_mem   = (op[2] == 1'b0);
        operand  = ram[prm];
        old_akku = m_akku;

        m_pc = pc;
        case (op)
            3'd0: begin m_akku = operand; m_zero = (m_akku == 0); end
            3'd1: ram[prm] = old_akku;
            3'd2: begin
                s       = int'(old_akku) + int'(operand);
                m_carry = (s > 255);
                m_akku  = 8'(s % 256);
                m_zero  = (m_akku == 0);
            end
            3'd3: begin
                m_carry = (int'(old_akku) < int'(operand));
                m_akku  = 8'((int'(old_akku) - int'(operand) + 256) % 256);
                m_zero  = (m_akku == 0);
            end
            3'd4: m_pc = 8'(prm);
            3'd5: if (old_akku == 0) m_pc = 8'(prm);
            3'd6: begin m_akku = 8'(prm); m_zero = (prm == 0); end
            default: m_halted = 1'b1;
        endcase

        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        param  = prm;
        pc_in  = pc;
        @(negedge clk);
        start  = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_early", done, 0);

        if (is_mem) begin
            check("req_rd", mem_rd, (op != 3'd1));
            check("req_wr", mem_wr, (op == 3'd1));
            check("req_addr", mem_addr, prm);
            if (op == 3'd1) check("req_wdata", mem_wdata, old_akku);
            for (int i = 0; i < wait_n; i++) begin
                if (stray && i == 0) begin
                    start  = 1'b1;
                    opcode = 3'b110;
                    param  = 5'h1f;
                    pc_in  = 8'hAA;
                end
                @(negedge clk);
                start = 1'b0;
                check("hold_req", {mem_rd, mem_wr}, {(op != 3'd1), (op == 3'd1)});
                check("hold_addr", mem_addr, prm);
                check("hold_done", done, 0);
            end
            mem_ack   = 1'b1;
            mem_rdata = (op == 3'd1) ? 8'($urandom) : operand;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            check("req_dropped", {mem_rd, mem_wr}, 0);
            check("done_before_wb", done, 0);
        end else begin
            // A stray ack with no request pending must be ignored.
            mem_ack   = 1'b1;
            mem_rdata = 8'($urandom);
            @(negedge clk);
            mem_ack   = 1'b0;
            check("done_mid", done, 0);
            check("no_req", {mem_rd, mem_wr}, 0);
        end

        @(negedge clk);
        check("done_pulse", done, 1);
        check("akku", akku, m_akku);
        check("zero", zero, m_zero);
        check("carry", carry, m_carry);
        check("pc_next", pc_next, m_pc);
        check("halted", halted, m_halted);
        check("busy_after_done", busy, 0);
        check("err", err, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        opcode    = 3'd0;
        param     = 5'd0;
        pc_in     = 8'd0;
        mem_rdata = 8'd0;
        mem_ack   = 1'b0;
        model_reset();
        for (int i = 0; i < 32; i++) ram[i] = 8'($urandom);
        ram[1] = 8'hF0;
        ram[2] = 8'h20;
        ram[3] = 8'h05;
        ram[5] = 8'hA5;

        // Reset state.
        #12;
        check_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // LDI immediate with zero-cycle latency path.
        exec(3'd6, 5'd5, 8'd3, 0, 1'b0);

        // ADD with carry-out and three wait cycles.
        exec(3'd0, 5'd1, 8'd4, 0, 1'b0);
        exec(3'd2, 5'd2, 8'd5, 3, 1'b0);

        // SUB with borrow, then SUB down to zero.
        exec(3'd6, 5'd3, 8'd6, 0, 1'b0);
        exec(3'd3, 5'd3, 8'd7, 1, 1'b0);
        exec(3'd6, 5'd5, 8'd8, 0, 1'b0);
        exec(3'd3, 5'd3, 8'd9, 0, 1'b0);

        // STA to the top address, with a stray start while busy.
        exec(3'd0, 5'd5, 8'd10, 0, 1'b0);
        exec(3'd1, 5'd31, 8'd11, 2, 1'b1);

        // Branches.
        exec(3'd6, 5'd0, 8'd12, 0, 1'b0);
        exec(3'd5, 5'd9, 8'd4, 0, 1'b0);
        exec(3'd6, 5'd1, 8'd13, 0, 1'b0);
        exec(3'd5, 5'd9, 8'd4, 0, 1'b0);
        exec(3'd4, 5'd31, 8'd14, 0, 1'b0);

        // Random instruction mix (HLT excluded).
        for (int n = 0; n < 60; n++) begin
            logic [2:0] rop;
            logic [4:0] rprm;
            logic [7:0] rpc;
            int         rw;
            rop  = 3'($urandom_range(0, 6));
            rprm = 5'($urandom);
            rpc  = 8'($urandom);
            rw   = $urandom_range(0, 4);
            exec(rop, rprm, rpc, rw, (rw > 0) && ($urandom_range(0, 1) == 1));
        end

        // HLT, then confirm later starts are ignored.
        exec(3'd7, 5'd0, 8'd21, 0, 1'b0);
        @(negedge clk);
        start  = 1'b1;
        opcode = 3'd6;
        param  = 5'd17;
        pc_in  = 8'd30;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("halt_ignores_start.done", done, 0);
        check("halt_ignores_start.busy", busy, 0);
        check("halt_ignores_start.akku", akku, m_akku);
        check("halt_sticky", halted, 1);

        // Reset while a read is in flight.
        resetn = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset_from_halt");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        opcode = 3'd0;
        param  = 5'd7;
        pc_in  = 8'd40;
        @(negedge clk);
        start = 1'b0;
        check("abort.req_up", mem_rd, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        resetn = 1'b1;

`ifdef UL8_MEM_TIMEOUT_EN
        // No ack: the request is dropped after 15 cycles.
        exec(3'd6, 5'd9, 8'd1, 0, 1'b0);
        @(negedge clk);
        start  = 1'b1;
        opcode = 3'd0;
        param  = 5'd4;
        pc_in  = 8'd50;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check("to_wait.rd", mem_rd, 1);
            check("to_wait.err", err, 0);
        end
        @(negedge clk);
        check("to.rd_dropped", mem_rd, 0);
        check("to.err", err, 1);
        check("to.done", done, 1);
        check("to.halted", halted, 1);
        check("to.akku_kept", akku, m_akku);
        check("to.pc_kept", pc_next, m_pc);
        @(negedge clk);
        check("to.done_one_cycle", done, 0);
        check("to.err_sticky", err, 1);
`else
        // Without the timeout, a very slow ack still completes normally.
        exec(3'd0, 5'd4, 8'd50, 20, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
